// File: rtl/n64_vinfo_ext_gen2.sv
// Video-info extractor for the N64 digital video bus: compatibility vector plus
// measured field/line geometry, debounced PAL/480i detection and a sync-valid flag.
module n64_vinfo_ext_gen2 #(
  parameter int unsigned LINE_CNT_W      = 10,
  parameter int unsigned PIX_CNT_W       = 10,
  parameter int unsigned PAL_LINE_THRESH = 288,
  parameter int unsigned CONFIRM_FIELDS  = 2
) (
  input  logic                  VCLK,
  input  logic                  nRST,
  input  logic                  nDSYNC,
  input  logic [3:0]            Sync_pre,
  input  logic [3:0]            Sync_cur,
  output logic [3:0]            vinfo_o,
  output logic [LINE_CNT_W-1:0] lines_per_field,
  output logic [PIX_CNT_W-1:0]  slots_per_line,
  output logic                  new_field,
  output logic                  vinfo_valid
);

  localparam int unsigned           CONF_W   = 4;
  localparam logic [LINE_CNT_W-1:0] LINE_MAX = '1;
  localparam logic [PIX_CNT_W-1:0]  SLOT_MAX = '1;
  localparam logic [LINE_CNT_W-1:0] PAL_TH   = LINE_CNT_W'(PAL_LINE_THRESH);
  localparam logic [CONF_W-1:0]     CONF_TGT = CONF_W'(CONFIRM_FIELDS);

  logic [1:0]            data_cnt_q, data_cnt_d;
  logic                  vmode_q, vmode_d;
  logic                  n64_480i_q, n64_480i_d;
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [PIX_CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
  logic [LINE_CNT_W-1:0] lines_per_field_q, lines_per_field_d;
  logic [PIX_CNT_W-1:0]  slots_per_line_q, slots_per_line_d;
  logic                  new_field_q, new_field_d;
  logic                  parity_q, parity_d;
  logic [CONF_W-1:0]     vconf_q, vconf_d;
  logic [CONF_W-1:0]     iconf_q, iconf_d;
  logic                  field_seen_q, field_seen_d;
  logic                  vinfo_valid_q, vinfo_valid_d;

  logic slot_c, pos_v_c, neg_v_c, pos_h_c, neg_h_c;
  logic pal_cand_c, il_cand_c;
  logic [CONF_W-1:0] vconf_inc_c, iconf_inc_c;
  logic unused_sync_c;

  // Sync edges only exist inside a sample slot.
  assign slot_c        = ~nDSYNC;
  assign pos_v_c       = slot_c & ~Sync_pre[3] &  Sync_cur[3];
  assign neg_v_c       = slot_c &  Sync_pre[3] & ~Sync_cur[3];
  assign pos_h_c       = slot_c & ~Sync_pre[1] &  Sync_cur[1];
  assign neg_h_c       = slot_c &  Sync_pre[1] & ~Sync_cur[1];
  assign pal_cand_c    = (line_cnt_q >= PAL_TH);
  assign il_cand_c     = neg_h_c ^ parity_q;
  assign vconf_inc_c   = vconf_q + CONF_W'(1);
  assign iconf_inc_c   = iconf_q + CONF_W'(1);
  assign unused_sync_c = ^{Sync_pre[2], Sync_pre[0], Sync_cur[2], Sync_cur[0]};

  always_comb begin
    data_cnt_d        = data_cnt_q + 2'd1;
    vmode_d           = vmode_q;
    n64_480i_d        = n64_480i_q;
    line_cnt_d        = line_cnt_q;
    slot_cnt_d        = slot_cnt_q;
    lines_per_field_d = lines_per_field_q;
    slots_per_line_d  = slots_per_line_q;
    new_field_d       = 1'b0;
    parity_d          = parity_q;
    vconf_d           = vconf_q;
    iconf_d           = iconf_q;
    field_seen_d      = field_seen_q;
    vinfo_valid_d     = vinfo_valid_q;

    if (slot_c) begin
      data_cnt_d = 2'b01;
      if (pos_h_c) begin
        slots_per_line_d = slot_cnt_q;
        slot_cnt_d       = PIX_CNT_W'(1);
      end else begin
        slot_cnt_d = (slot_cnt_q == SLOT_MAX) ? SLOT_MAX : slot_cnt_q + PIX_CNT_W'(1);
      end
    end

    // Field start wins over a coincident line start; that posH is not counted.
    if (pos_v_c) begin
      lines_per_field_d = line_cnt_q;
      line_cnt_d        = '0;
      new_field_d       = 1'b1;
      field_seen_d      = 1'b1;
      if (field_seen_q && (line_cnt_q != LINE_MAX)) begin
        vinfo_valid_d = 1'b1;
      end
      if (pal_cand_c == vmode_q) begin
        vconf_d = '0;
      end else if (vconf_inc_c == CONF_TGT) begin
        vmode_d = pal_cand_c;
        vconf_d = '0;
      end else begin
        vconf_d = vconf_inc_c;
      end
    end else if (pos_h_c) begin
      line_cnt_d = (line_cnt_q == LINE_MAX) ? LINE_MAX : line_cnt_q + LINE_CNT_W'(1);
      // A saturated line count means nVSYNC was lost.
      if (line_cnt_d == LINE_MAX) begin
        field_seen_d  = 1'b0;
        vinfo_valid_d = 1'b0;
      end
    end

    if (neg_v_c) begin
      parity_d = neg_h_c;
      if (il_cand_c == n64_480i_q) begin
        iconf_d = '0;
      end else if (iconf_inc_c == CONF_TGT) begin
        n64_480i_d = il_cand_c;
        iconf_d    = '0;
      end else begin
        iconf_d = iconf_inc_c;
      end
    end
  end

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      data_cnt_q        <= 2'b00;
      vmode_q           <= 1'b0;
      n64_480i_q        <= 1'b1;
      line_cnt_q        <= '0;
      slot_cnt_q        <= '0;
      lines_per_field_q <= '0;
      slots_per_line_q  <= '0;
      new_field_q       <= 1'b0;
      parity_q          <= 1'b0;
      vconf_q           <= '0;
      iconf_q           <= '0;
      field_seen_q      <= 1'b0;
      vinfo_valid_q     <= 1'b0;
    end else begin
      data_cnt_q        <= data_cnt_d;
      vmode_q           <= vmode_d;
      n64_480i_q        <= n64_480i_d;
      line_cnt_q        <= line_cnt_d;
      slot_cnt_q        <= slot_cnt_d;
      lines_per_field_q <= lines_per_field_d;
      slots_per_line_q  <= slots_per_line_d;
      new_field_q       <= new_field_d;
      parity_q          <= parity_d;
      vconf_q           <= vconf_d;
      iconf_q           <= iconf_d;
      field_seen_q      <= field_seen_d;
      vinfo_valid_q     <= vinfo_valid_d;
    end
  end

  assign vinfo_o         = {data_cnt_q, vmode_q, n64_480i_q};
  assign lines_per_field = lines_per_field_q;
  assign slots_per_line  = slots_per_line_q;
  assign new_field       = new_field_q;
  assign vinfo_valid     = vinfo_valid_q;

endmodule

// File: tb/tb_n64_vinfo_ext_gen2.sv
// Randomised scoreboard bench for n64_vinfo_ext_gen2: a field/line generator feeds
// an event-level reference model whose per-field expectations a monitor checks.
module tb_n64_vinfo_ext_gen2;

  localparam int LW = 10;
  localparam int PW = 10;
  localparam int CONF = 2;
  localparam int THRESH = 288;
  localparam int LMAX = 1023;

  logic          clk = 1'b0;
  logic          nRST = 1'b0;
  logic          nDSYNC = 1'b1;
  logic [3:0]    Sync_pre = 4'h0;
  logic [3:0]    Sync_cur = 4'h0;
  logic [3:0]    vinfo_o;
  logic [LW-1:0] lines_per_field;
  logic [PW-1:0] slots_per_line;
  logic          new_field;
  logic          vinfo_valid;

  always #5 clk = ~clk;

  n64_vinfo_ext_gen2 #(
    .LINE_CNT_W(LW), .PIX_CNT_W(PW), .PAL_LINE_THRESH(THRESH), .CONFIRM_FIELDS(CONF)
  ) dut (
    .VCLK(clk), .nRST(nRST), .nDSYNC(nDSYNC), .Sync_pre(Sync_pre), .Sync_cur(Sync_cur),
    .vinfo_o(vinfo_o), .lines_per_field(lines_per_field), .slots_per_line(slots_per_line),
    .new_field(new_field), .vinfo_valid(vinfo_valid)
  );

  typedef struct { int lines; int spl; bit vm; bit il; bit vld; } rec_t;
  rec_t sb_q[$];

  int tests = 0;
  int fails = 0;

  // Reference model state: counts of events since the last field start etc.
  int hcount, prev_len, spl_exp;
  bit seen, valid_m, par_m, v_lvl, h_lvl;
  bit mode_m [2];   // [0] = vmode, [1] = n64_480i
  int run_m [2];    // consecutive disagreeing candidates
  int pseq [9] = '{1, 0, 1, 0, 0, 1, 0, 1, 0};

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hcount = 0; prev_len = 0; spl_exp = 0;
    seen = 0; valid_m = 0; par_m = 0; v_lvl = 0; h_lvl = 0;
    mode_m[0] = 0; mode_m[1] = 1; run_m[0] = 0; run_m[1] = 0;
  endtask

  task automatic debounce(input int idx, input bit cand);
    if (cand == mode_m[idx]) run_m[idx] = 0;
    else begin
      run_m[idx]++;
      if (run_m[idx] >= CONF) begin
        mode_m[idx] = cand;
        run_m[idx] = 0;
      end
    end
  endtask

  // One sample slot with new sync levels, then optional idle cycles carrying junk sync.
  task automatic do_slot(input bit nv, input bit nh);
    bit pv, ngv, ph, ngh;
    rec_t r;
    int idle;
    nDSYNC = 1'b0;
    Sync_pre = {v_lvl, 1'($urandom), h_lvl, 1'($urandom)};
    Sync_cur = {nv, 1'($urandom), nh, 1'($urandom)};
    @(posedge clk); #1;
    pv = !v_lvl && nv;  ngv = v_lvl && !nv;
    ph = !h_lvl && nh;  ngh = h_lvl && !nh;
    if (pv) begin
      debounce(0, hcount >= THRESH);
      if (seen && hcount < LMAX) valid_m = 1;
      seen = 1;
      r.lines = hcount; r.spl = spl_exp; r.vm = mode_m[0]; r.il = mode_m[1]; r.vld = valid_m;
      sb_q.push_back(r);
      hcount = 0;
    end else if (ph) begin
      hcount = (hcount < LMAX) ? hcount + 1 : LMAX;
      if (hcount == LMAX) begin seen = 0; valid_m = 0; end
    end
    if (ngv) begin
      debounce(1, ngh != par_m);
      par_m = ngh;
    end
    v_lvl = nv; h_lvl = nh;
    idle = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
    for (int i = 0; i < idle; i++) begin
      nDSYNC = 1'b1;
      Sync_pre = 4'($urandom);
      Sync_cur = 4'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // kind: 0 plain, 1 posV after line start, 2 posV with line start, 3 negV even, 4 negV odd
  task automatic line(input int len, input int kind);
    bit nv, nh;
    spl_exp = prev_len;
    prev_len = len;
    for (int k = 0; k < len; k++) begin
      nh = (k < len - 3);
      nv = v_lvl;
      case (kind)
        1: if (k == 1) nv = 1'b1;
        2: if (k == 0) nv = 1'b1;
        3: if (k == 2) nv = 1'b0;
        4: if (k == len - 3) nv = 1'b0;
        default: ;
      endcase
      do_slot(nv, nh);
    end
  endtask

  task automatic field(input int n, input int len, input bit odd, input bit coinc, input int last_len);
    line(len, coinc ? 2 : 1);
    for (int i = 1; i < n; i++)
      line((i == n - 1 && last_len != 0) ? last_len : len, (i == n - 2) ? (odd ? 4 : 3) : 0);
  endtask

  task automatic apply_reset();
    nRST = 1'b0; nDSYNC = 1'b0;
    Sync_pre = 4'b0000; Sync_cur = 4'b1010;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vinfo_o", int'(vinfo_o), 1);
    chk("rst_lines_per_field", int'(lines_per_field), 0);
    chk("rst_slots_per_line", int'(slots_per_line), 0);
    chk("rst_new_field", int'(new_field), 0);
    chk("rst_vinfo_valid", int'(vinfo_valid), 0);
    model_reset();
    nRST = 1'b1;
  endtask

  // Monitor: data_cnt every cycle, field records on every new_field pulse.
  logic [1:0] exp_dc = 2'd0;
  bit have_prev = 0, prev_nrst = 0, prev_nd = 1;
  always @(negedge clk) begin
    rec_t r;
    if (have_prev) begin
      if (!prev_nrst) exp_dc = 2'd0;
      else if (!prev_nd) exp_dc = 2'd1;
      else exp_dc = exp_dc + 2'd1;
      chk("data_cnt", int'(vinfo_o[3:2]), int'(exp_dc));
    end
    prev_nrst = nRST; prev_nd = nDSYNC; have_prev = 1;
    if (new_field === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL new_field_unexpected: got pulse, expected none (t=%0t)", $time);
      end else begin
        r = sb_q.pop_front();
        chk("lines_per_field", int'(lines_per_field), r.lines);
        chk("slots_per_line", int'(slots_per_line), r.spl);
        chk("vmode", int'(vinfo_o[1]), int'(r.vm));
        chk("n64_480i", int'(vinfo_o[0]), int'(r.il));
        chk("vinfo_valid", int'(vinfo_valid), int'(r.vld));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    apply_reset();
    // NTSC progressive, even parity only
    repeat (3) field(262, $urandom_range(8, 10), 0, 0, 0);
    // PAL with one NTSC field inserted
    repeat (2) field(312, 8, 0, 0, 0);
    field(262, 8, 0, 0, 0);
    field(312, 8, 0, 0, 0);
    // alternating parity with one repeated parity
    foreach (pseq[i]) field($urandom_range(40, 80), $urandom_range(8, 12), pseq[i][0], 0, 0);
    // long line, then a field whose posV coincides with posH
    field(60, 9, 0, 0, 773);
    field(60, 9, 1, 1, 0);
    field(50, 10, 0, 0, 0);
    // lost nVSYNC: line counter saturates, then sync resumes
    field(1030, 8, 0, 0, 0);
    repeat (3) field($urandom_range(90, 110), 8, 0, 0, 0);
    // reset mid-field
    line(9, 1);
    repeat (20) line(9, 0);
    apply_reset();
    repeat (3) field(262, $urandom_range(8, 10), 0, 0, 0);
    line(9, 1);
    repeat (3) line(9, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/n64_vinfo_ext_gen2.md
Name: n64_vinfo_ext_gen2

Overview:
Parametrised successor video-info extractor for the N64 digital video bus. Outputs the same compatibility vector {data_cnt, vmode, n64_480i}. Adds measured lines-per-field and sample-slots-per-line. Mode decisions (PAL/NTSC, 240p/480i) are debounced over a configurable number of fields, and a sync-valid flag is provided. Sits directly after the input sync register stage and feeds the de-mux, the OSD/scanline logic and the filter-mode logic.

Parameters:
LINE_CNT_W, 10, width of line counter and lines_per_field output
PIX_CNT_W, 10, width of slot counter and slots_per_line output
PAL_LINE_THRESH, 288, lines_per_field >= this means PAL candidate
CONFIRM_FIELDS, 2, consecutive agreeing fields required to change vmode or n64_480i (range 1..15)

Ports:
VCLK  in  1  video clock
nRST  in  1  synchronous active-low reset, sampled on posedge VCLK
nDSYNC  in  1  data sync; low marks a sample slot
Sync_pre  in  4  previous sync nibble; [3]=nVSYNC, [1]=nHSYNC
Sync_cur  in  4  current sync nibble, same order
vinfo_o  out  4  {data_cnt[1:0], vmode, n64_480i}
lines_per_field  out  LINE_CNT_W  nHSYNC rising edges counted in last complete field
slots_per_line  out  PIX_CNT_W  sample slots counted in last complete line
new_field  out  1  one-VCLK pulse per detected field start
vinfo_valid  out  1  measurements trustworthy

Behaviour:
- Edge terms: posV = !pre[3]&cur[3]; negV = pre[3]&!cur[3]; posH = !pre[1]&cur[1]; negH = pre[1]&!cur[1].
- Edge terms are evaluated only in a slot (nDSYNC=0). All outputs are registered and update on the VCLK edge that samples the slot (1-cycle latency).
- Reset (nRST=0 at posedge VCLK): data_cnt=00, vmode=0 (NTSC), n64_480i=1, lines_per_field=0, slots_per_line=0, new_field=0, vinfo_valid=0. Internal counters, parity, confirm counters and field_seen are all cleared. Reset overrides every other event.
- data_cnt: nDSYNC=0 -> 01; else increments with 2-bit wrap.
- Line counter: posH -> +1, saturating at all-ones. posV -> lines_per_field<=counter, counter<=0, new_field=1 for that cycle. If posV and posH occur in the same slot, posV wins and that posH is not counted.
- Slot counter: +1 per slot, saturating. On posH -> slots_per_line<=counter, counter<=1 (the current slot counts). If posH occurs in the same slot as posV, the line latch still happens.
- Field parity on negV: negH in the same slot -> odd (1), else even (0). il_cand = (new parity != previous parity). Store the new parity.
- vmode candidate on posV: pal_cand = (counter >= PAL_LINE_THRESH).
- Debounce, applied independently to vmode (on posV) and n64_480i (on negV):
  - If the candidate equals the current output, its confirm counter is set to 0.
  - Otherwise the confirm counter is incremented. When it reaches CONFIRM_FIELDS, the output takes the candidate and the counter is set to 0.
  - CONFIRM_FIELDS=1 gives immediate change, matching the legacy block's behaviour.
- Validity:
  - field_seen is set on posV.
  - vinfo_valid is set on posV when field_seen=1 and the line counter is not saturated.
  - vinfo_valid and field_seen are cleared when the line counter saturates (lost nVSYNC). vmode and n64_480i hold their values.
- Sync edges outside slots are ignored entirely.

Test Plan:
1. Reset, then 262-line fields with even parity only (CONFIRM_FIELDS=2) -> lines_per_field=262, vmode=0. n64_480i goes 1->0 at the second negV with no parity change, then stays 0. vinfo_valid=1 from the 2nd posV.
2. 312-line fields -> vmode goes 0->1 at the 2nd consecutive posV. A single 262-line field inserted between PAL fields -> vmode stays 1.
3. Alternating odd/even fields (negH coincident with negV on odd fields) -> n64_480i=1 persists. One glitched repeat of the same parity -> no change.
4. Line of 773 slots -> slots_per_line=773. posV and posH in the same slot -> the line counter restarts at 0, not 1. Edges asserted with nDSYNC=1 -> no counter change.
5. Hold nVSYNC high for >1023 lines -> lines counter saturates at 1023, vinfo_valid drops to 0. Sync resumes -> valid returns at the 2nd subsequent posV.
6. nRST asserted mid-field -> all outputs take reset values on the next edge, with data_cnt=00 even if nDSYNC=0 in that cycle. Release -> normal counting resumes.
